// File: rtl/readout_slot_scheduler.sv
// readout_slot_scheduler: time-division grant of one readout pair among binary-rate cores
module readout_slot_scheduler #(
  parameter int N_CORES = 8,
  parameter int ID_W    = 5
) (
  input  logic               clk_master,
  input  logic               reset,
  input  logic               enable,
  input  logic [N_CORES-1:0] in_eve,
  input  logic [N_CORES-1:0] in_pol_eve,
  output logic [N_CORES-1:0] gray_out,
  output logic [N_CORES-1:0] ctrlb,
  output logic               out_eve,
  output logic               out_pol_eve,
  output logic               out_valid,
  output logic [ID_W-1:0]    out_core_id,
  output logic               frame_end,
  output logic               busy
);
  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;
  state_t state, state_nxt;
  logic [N_CORES-1:0] cnt, cnt_inc, grant;
  logic [ID_W-1:0] tz;
  logic tz_done, idle_slot, proc;
  assign cnt_inc   = cnt + N_CORES'(1);
  assign idle_slot = &cnt;
  assign proc      = state != IDLE;
  assign grant     = idle_slot ? '0 : N_CORES'(1) << tz;
  // slot owner is the number of trailing ones in the counter
  always_comb begin
    tz = '0;
    tz_done = 1'b0;
    for (int i = 0; i < N_CORES; i++) begin
      if (!tz_done && cnt[i]) tz = tz + 1'b1;
      else tz_done = 1'b1;
    end
  end
  // stopping only ever happens on the idle slot, so frames are never cut short
  always_comb begin
    state_nxt = state == IDLE ? (enable ? RUN : IDLE)
              : enable ? RUN
              : idle_slot ? IDLE : DRAIN;
  end
  always_ff @(posedge clk_master) begin
    if (reset) begin
      state       <= IDLE;
      cnt         <= '0;
      gray_out    <= '0;
      ctrlb       <= '1;
      out_eve     <= 1'b0;
      out_pol_eve <= 1'b0;
      out_valid   <= 1'b0;
      out_core_id <= '0;
      frame_end   <= 1'b0;
      busy        <= 1'b0;
    end else begin
      state <= state_nxt;
      busy  <= state_nxt != IDLE;
      if (proc) begin
        cnt         <= cnt_inc;
        gray_out    <= cnt_inc ^ (cnt_inc >> 1);
        ctrlb       <= ~grant;
        out_eve     <= |(in_eve & grant);
        out_pol_eve <= |(in_pol_eve & grant);
        out_valid   <= !idle_slot;
        out_core_id <= idle_slot ? '0 : tz;
        frame_end   <= idle_slot;
      end else begin
        ctrlb       <= '1;
        out_eve     <= 1'b0;
        out_pol_eve <= 1'b0;
        out_valid   <= 1'b0;
        out_core_id <= '0;
        frame_end   <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_readout_slot_scheduler.sv
// tb_readout_slot_scheduler: directed checks of the slot schedule on 3-core and 8-core instances
module tb_readout_slot_scheduler;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic en3 = 1'b0, en8 = 1'b0;
  logic [2:0] ie3 = '0, ip3 = '0;
  logic [7:0] ie8 = '0, ip8 = '0;
  logic [2:0] g3, cb3;
  logic [1:0] id3;
  logic ev3, pv3, vl3, fe3, bz3;
  logic [7:0] g8, cb8;
  logic [4:0] id8;
  logic ev8, pv8, vl8, fe8, bz8;
  int n_cmp = 0, n_err = 0;

  always #5 clk = ~clk;

  readout_slot_scheduler #(.N_CORES(3), .ID_W(2)) u3 (
    .clk_master(clk), .reset(reset), .enable(en3), .in_eve(ie3), .in_pol_eve(ip3),
    .gray_out(g3), .ctrlb(cb3), .out_eve(ev3), .out_pol_eve(pv3), .out_valid(vl3),
    .out_core_id(id3), .frame_end(fe3), .busy(bz3));

  readout_slot_scheduler u8 (
    .clk_master(clk), .reset(reset), .enable(en8), .in_eve(ie8), .in_pol_eve(ip8),
    .gray_out(g8), .ctrlb(cb8), .out_eve(ev8), .out_pol_eve(pv8), .out_valid(vl8),
    .out_core_id(id8), .frame_end(fe8), .busy(bz8));

  // expected per-slot values for a 3-core frame, slots 0..7
  logic [1:0] id_t   [8] = '{0, 1, 0, 2, 0, 1, 0, 0};
  logic [2:0] ctrl_t [8] = '{3'b110, 3'b101, 3'b110, 3'b011, 3'b110, 3'b101, 3'b110, 3'b111};
  logic [2:0] gray_t [8] = '{3'd1, 3'd3, 3'd2, 3'd6, 3'd7, 3'd5, 3'd4, 3'd0};
  logic       eve_t  [8] = '{0, 1, 0, 0, 0, 1, 0, 0};
  logic       pol_t  [8] = '{0, 0, 0, 1, 0, 0, 0, 0};

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_slot3(input int s);
    chk("slot_id", 32'(id3), 32'(id_t[s]));
    chk("slot_ctrlb", 32'(cb3), 32'(ctrl_t[s]));
    chk("slot_valid", 32'(vl3), 32'(s != 7));
    chk("slot_frame_end", 32'(fe3), 32'(s == 7));
    chk("slot_gray", 32'(g3), 32'(gray_t[s]));
  endtask

  task automatic chk_reset3(input string tag);
    chk({tag, "_ctrlb"}, 32'(cb3), 32'h7);
    chk({tag, "_gray"}, 32'(g3), 32'h0);
    chk({tag, "_valid"}, 32'(vl3), 32'h0);
    chk({tag, "_id"}, 32'(id3), 32'h0);
    chk({tag, "_eve"}, 32'(ev3), 32'h0);
    chk({tag, "_pol"}, 32'(pv3), 32'h0);
    chk({tag, "_fe"}, 32'(fe3), 32'h0);
    chk({tag, "_busy"}, 32'(bz3), 32'h0);
  endtask

  initial begin
    logic [7:0] prev;
    logic [7:0] diff;
    int idx;
    step();
    step();
    chk_reset3("reset");
    chk("reset8_ctrlb", 32'(cb8), 32'hff);
    reset = 1'b0;
    en3 = 1'b1;
    ie3 = 3'b111;
    ip3 = 3'b111;
    step();
    chk("start_busy", 32'(bz3), 32'h1);
    chk("start_valid", 32'(vl3), 32'h0);
    for (int i = 0; i < 16; i++) begin
      step();
      chk_slot3(i % 8);
      chk("slot_eve", 32'(ev3), 32'(i % 8 != 7));
    end
    ie3 = 3'b010;
    ip3 = 3'b100;
    for (int s = 0; s < 8; s++) begin
      step();
      chk("route_eve", 32'(ev3), 32'(eve_t[s]));
      chk("route_pol", 32'(pv3), 32'(pol_t[s]));
    end
    // stop after slot 2: drain slots 3..7 then idle
    for (int s = 0; s < 3; s++) step();
    chk("pre_stop_id", 32'(id3), 32'h0);
    en3 = 1'b0;
    for (int s = 3; s < 7; s++) begin
      step();
      chk_slot3(s);
      chk("drain_busy", 32'(bz3), 32'h1);
    end
    step();
    chk_slot3(7);
    chk("stop_busy", 32'(bz3), 32'h0);
    step();
    chk_reset3("idle");
    step();
    chk_reset3("idle_hold");
    // restart, drop at slot 2, reassert during drain before slot 5
    en3 = 1'b1;
    step();
    chk("restart_busy", 32'(bz3), 32'h1);
    chk("restart_valid", 32'(vl3), 32'h0);
    for (int s = 0; s < 3; s++) begin
      step();
      chk_slot3(s);
    end
    en3 = 1'b0;
    for (int s = 3; s < 5; s++) begin
      step();
      chk_slot3(s);
      chk("drain2_busy", 32'(bz3), 32'h1);
    end
    en3 = 1'b1;
    for (int s = 5; s < 8; s++) begin
      step();
      chk_slot3(s);
      chk("resume_busy", 32'(bz3), 32'h1);
    end
    // reset mid-frame before slot 4
    for (int s = 0; s < 4; s++) step();
    chk("pre_reset_id", 32'(id3), 32'h2);
    reset = 1'b1;
    step();
    chk_reset3("midreset");
    reset = 1'b0;
    step();
    chk("rel_busy", 32'(bz3), 32'h1);
    chk("rel_valid", 32'(vl3), 32'h0);
    chk("rel_gray", 32'(g3), 32'h0);
    step();
    chk_slot3(0);
    en3 = 1'b0;
    // 8-core gray walk over one full frame
    en8 = 1'b1;
    step();
    chk("g8_start_gray", 32'(g8), 32'h0);
    prev = g8;
    for (int i = 0; i < 256; i++) begin
      step();
      diff = g8 ^ prev;
      idx = -1;
      for (int b = 0; b < 8; b++) if (diff[b]) idx = b;
      chk("g8_onebit", 32'($countones(diff)), 32'h1);
      chk("g8_index", 32'(idx), vl8 ? 32'(id8) : 32'h7);
      chk("g8_code", 32'(g8), 32'(((i + 1) % 256) ^ (((i + 1) % 256) >> 1)));
      if (i == 254) chk("g8_pre_wrap", 32'(g8), 32'h80);
      prev = g8;
    end
    chk("g8_wrap_fe", 32'(fe8), 32'h1);
    chk("g8_wrap_ctrlb", 32'(cb8), 32'hff);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/readout_slot_scheduler.md
# readout_slot_scheduler

Time-division scheduler that shares one readout output pair (event, polarity-event) among `N_CORES` filter-bank cores running at binary-divided rates. A binary slot counter drives a gray-coded readout clock. Each cycle it grants the bus to the core whose gray bit toggles in that slot: core k gets 1 of every 2^(k+1) slots. The block sits between the per-core readout tri-state stages and the chip output pads. It generates their active-low enables and a registered copy of the granted data.

## Interface
Parameters:
- `N_CORES`, default 8: number of cores sharing the bus; legal range 2..19.
- `ID_W`, default 5: width of the core-id output; must satisfy 2^ID_W > N_CORES.

Ports:
- `clk_master`, in, 1: single clock; all state changes on its rising edge.
- `reset`, in, 1: synchronous, active-high.
- `enable`, in, 1: level request to run the schedule.
- `in_eve`, in, N_CORES: per-core event bit; bit k belongs to core k.
- `in_pol_eve`, in, N_CORES: per-core polarity-event bit.
- `gray_out`, out, N_CORES: gray code of the slot counter; registered.
- `ctrlb`, out, N_CORES: active-low one-hot tri-state enables; all-ones means no core drives.
- `out_eve`, out, 1: registered event bit of the granted core.
- `out_pol_eve`, out, 1: registered polarity-event bit of the granted core.
- `out_valid`, out, 1: high when the outputs carry a granted slot.
- `out_core_id`, out, ID_W: index of the granted core; 0 when not valid.
- `frame_end`, out, 1: one-cycle pulse on the idle slot that closes a frame.
- `busy`, out, 1: high in RUN or DRAIN.

## Operation
- Slot counter `cnt` is N_CORES bits wide and binary; frame length is 2^N_CORES slots.
- Slot owner is tz(cnt) = number of trailing ones of `cnt`. When `cnt` is all ones, the slot is idle and no core is granted.
- States:
  - IDLE: `cnt` = 0; outputs held at reset values.
    - `enable`=1 → RUN on the next edge. No slot is processed on that edge.
  - RUN: each edge processes slot `cnt` and increments `cnt`, wrapping all-ones → 0.
    - `enable`=0 on an edge that processes a non-idle slot → DRAIN.
    - `enable`=0 on the edge that processes the idle slot → IDLE.
    - The slot on the edge that leaves RUN is still processed.
  - DRAIN: keeps processing slots.
    - Processing the idle slot → IDLE.
    - `enable`=1 on any DRAIN edge → RUN; the schedule continues with no gap.
- Per processed slot with counter value c, on the same edge:
  - Non-idle c, k = tz(c):
    - `ctrlb` ← ~(1<<k)
    - `out_eve` ← `in_eve[k]`, `out_pol_eve` ← `in_pol_eve[k]`
    - `out_core_id` ← k, `out_valid` ← 1, `frame_end` ← 0
  - Idle c (all ones):
    - `ctrlb` ← all ones
    - `out_eve`, `out_pol_eve`, `out_core_id`, `out_valid` ← 0
    - `frame_end` ← 1
  - `cnt` ← c+1 mod 2^N_CORES.
  - `gray_out` ← g(c+1), where g(x) = x ^ (x>>1).
- On an edge that enters IDLE:
  - The processed slot's outputs are written as above.
  - On the following edge, data outputs, `ctrlb` and `frame_end` return to reset values; `cnt` is already 0.
- Exactly one bit of `gray_out` changes per processed slot. The changing bit index equals the granted core, or bit N_CORES-1 on the idle slot.

## Timing
- Reset values when `reset`=1 on an edge. Reset wins over every other input, in any state, mid-frame included:
  - state IDLE, `cnt` 0, `gray_out` 0
  - `ctrlb` all ones
  - `out_eve`, `out_pol_eve`, `out_valid`, `out_core_id`, `frame_end`, `busy`: 0
- Latency:
  - Inputs are sampled on the processing edge; outputs are valid one cycle later.
  - `ctrlb`, data and `gray_out` update together on that edge; there is no combinational path from inputs to outputs.
  - First granted slot: `enable` high at edge E0 → RUN at E0; slot 0 processed at E1. `out_valid`=1 and `out_core_id`=0 visible after E1.
- `busy` is registered and follows state: 1 after the edge entering RUN, 0 after the edge entering IDLE.
- `ctrlb` never has more than one zero bit in any cycle.
- `enable` toggling within a frame never skips, repeats or reorders slots. Stop is always frame-aligned.

## Test plan
- N_CORES=3, `enable` held 1, all `in_*`=1, 16 cycles:
  - `out_core_id` sequence 0,1,0,2,0,1,0,— repeating, with `out_valid` 0 and `frame_end` 1 on every 8th slot.
  - `ctrlb` steps through 110,101,110,011,110,101,110,111.
- Data routing:
  - `in_eve`=3'b010, `in_pol_eve`=3'b100.
  - `out_eve`=1 only on core-1 slots; `out_pol_eve`=1 only on core-2 slots.
  - Both are 0 on the idle slot.
- Gray check, N_CORES=8, one full 256-slot frame:
  - `gray_out` changes by exactly one bit per cycle, and the changing index equals `out_core_id`.
  - Wraps from 8'h80 to 0.
- Stop/restart, N_CORES=3:
  - Drop `enable` after slot 2 processed → `busy` stays 1 until slots 3..7 complete, then IDLE with `ctrlb`=111.
  - Reassert `enable` during DRAIN at slot 5 → slot 6 follows with no gap, `busy` never drops.
- Reset mid-frame: assert `reset` at slot 4 with `enable`=1.
  - Next cycle: all outputs at reset values.
  - After release with `enable`=1: first grant is core 0 two edges later, and `gray_out` sequence restarts at 1.
